led_pwm_fader: RTL and testbench



---
 rtl/led_pwm_fader.sv | 142 ++++++++++++++
 tb/tb_led_pwm_fader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: accepts a WIDTH-bit on/off target pattern over a valid/ready
// handshake and fades each LED linearly toward full brightness (bit=1) or off
// (bit=0). Each LED is driven by an 8-bit PWM comparator against a shared
// free-running counter. One brightness step is taken every STEP_DIV cycles.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   pat_valid  pat_data is offered
//   pat_ready  block can accept a pattern (idle)
//   pat_data   target pattern, one bit per LED
//   leds       registered PWM outputs
//   busy       a fade is in progress
module led_pwm_fader #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [WIDTH-1:0] pat_data,
  output logic [WIDTH-1:0] leds,
  output logic             busy
);

  localparam int unsigned PrescW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] LevelMax  = '1;
  localparam logic [PWM_BITS-1:0] LevelZero = '0;
  localparam logic [PWM_BITS-1:0] LevelOne  = PWM_BITS'(1);
  localparam logic [PrescW-1:0]   PrescLast = PrescW'(STEP_DIV - 1);
  localparam logic [PrescW-1:0]   PrescOne  = PrescW'(1);

  typedef enum logic [0:0] {
    StIdle,
    StFade
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    target_q, target_d;
  logic [PWM_BITS-1:0] level_q [WIDTH];
  logic [PWM_BITS-1:0] level_d [WIDTH];
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [WIDTH-1:0]    leds_q, leds_d;

  logic accept;
  logic tick;
  logic settled;

  assign pat_ready = (state_q == StIdle);
  assign busy      = (state_q == StFade);
  assign leds      = leds_q;

  assign accept = pat_valid && pat_ready;
  assign tick   = (presc_q == PrescLast);

  always_comb begin
    settled = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (target_q[i] ? (level_q[i] != LevelMax) : (level_q[i] != LevelZero)) begin
        settled = 1'b0;
      end
    end
  end

  // Saturating per-LED step, only on the prescaler tick while fading.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      level_d[i] = level_q[i];
      if ((state_q == StFade) && tick) begin
        if (target_q[i] && (level_q[i] != LevelMax)) begin
          level_d[i] = level_q[i] + LevelOne;
        end else if (!target_q[i] && (level_q[i] != LevelZero)) begin
          level_d[i] = level_q[i] - LevelOne;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      leds_d[i] = (level_q[i] > pwm_cnt_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StFade;
          target_d = pat_data;
        end
      end
      StFade: begin
        // Checked every cycle, so an already-settled pattern leaves after one cycle.
        if (settled) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Prescaler free-runs in both states; an accepted pattern restarts it.
  always_comb begin
    if (accept || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PrescOne;
    end
  end

  assign pwm_cnt_d = pwm_cnt_q + LevelOne;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      target_q  <= '0;
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      leds_q    <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      leds_q    <= leds_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with STEP_DIV=4: handshake timing, fade
// durations, PWM duty per LED, backpressure, redundant pattern and async reset.
module tb_led_pwm_fader;

  localparam int unsigned W       = 16;
  localparam int          FadeLen = 1021;  // 255 steps * 4 cycles + FADE->IDLE edge

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         pat_valid = 1'b0;
  logic [W-1:0] pat_data = '0;
  logic         pat_ready;
  logic [W-1:0] leds;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int duty [W];

  // Independent model of the free-running PWM counter.
  logic [7:0] m_cnt;

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_cnt <= 8'd0;
    else         m_cnt <= m_cnt + 8'd1;
  end

  led_pwm_fader #(
    .WIDTH   (16),
    .PWM_BITS(8),
    .STEP_DIV(4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .pat_valid(pat_valid),
    .pat_ready(pat_ready),
    .pat_data (pat_data),
    .leds     (leds),
    .busy     (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] p);
    @(negedge clk);
    pat_valid = 1'b1;
    pat_data  = p;
    @(posedge clk);
    #1 pat_valid = 1'b0;
  endtask

  // Counts negedge samples with pat_ready low (and busy high) until ready returns.
  task automatic wait_ready(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (pat_ready) break;
      n++;
      if (busy) nb++;
    end
  endtask

  task automatic check_duty(input string tag, input logic [W-1:0] mask);
    for (int i = 0; i < W; i++) duty[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < W; i++) if (leds[i]) duty[i]++;
    end
    for (int i = 0; i < W; i++) begin
      check_val($sformatf("%s duty led%0d", tag, i), duty[i], mask[i] ? 32'd255 : 32'd0);
    end
  endtask

  task automatic check_dark(input string tag, input int cycles);
    int nz;
    nz = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (leds != '0) nz++;
    end
    check_val(tag, nz, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, mism;

    // Reset held with clock running.
    repeat (4) @(negedge clk);
    check_val("reset leds", leds, 0);
    check_val("reset pat_ready", pat_ready, 1);
    check_val("reset busy", busy, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Redundant pattern straight after reset: one-cycle busy pulse.
    send(16'h0000);
    wait_ready(n, nb);
    check_val("redundant ready-low cycles", n, 1);
    check_val("redundant busy cycles", nb, 1);
    check_dark("leds dark after reset", 512);

    // Single fade-in.
    send(16'h0001);
    wait_ready(n, nb);
    check_val("fade-in 0001 cycles", n, FadeLen);
    check_val("fade-in 0001 busy cycles", nb, FadeLen);
    check_duty("0001", 16'h0001);

    send(16'hFFFF);
    wait_ready(n, nb);
    check_val("fade-in FFFF cycles", n, FadeLen);
    check_duty("FFFF", 16'hFFFF);

    // Mixed: LEDs 0-7 must keep full-duty waveform, low only after pwm_cnt==255.
    send(16'h00FF);
    n    = 0;
    mism = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (leds[7:0] !== ((m_cnt != 8'd0) ? 8'hFF : 8'h00)) mism++;
      if (pat_ready) break;
      n++;
    end
    check_val("fade-out 00FF cycles", n, FadeLen);
    check_val("00FF held LEDs waveform errors", mism, 0);
    check_duty("00FF", 16'h00FF);

    // Backpressure: one ignored pulse mid-fade, then a held request.
    send(16'hFF00);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (pat_ready) break;
      n++;
      if (n == 400) begin
        pat_valid = 1'b1;
        pat_data  = 16'hAAAA;
      end else if (n == 401) begin
        pat_valid = 1'b0;
      end else if (n == 1000) begin
        pat_valid = 1'b1;
        pat_data  = 16'hAAAA;
      end
    end
    check_val("FF00 fade cycles despite pulse", n, FadeLen);
    @(posedge clk);
    #1 pat_valid = 1'b0;
    @(negedge clk);
    check_val("held request accepted: ready", pat_ready, 0);
    check_val("held request accepted: busy", busy, 1);
    wait_ready(n, nb);
    check_val("AAAA fade remaining cycles", n, FadeLen - 1);
    check_duty("AAAA", 16'hAAAA);

    send(16'h0000);
    wait_ready(n, nb);
    check_val("fade-out 0000 cycles", n, FadeLen);

    // Asynchronous reset around step 100 of a full fade-in.
    send(16'hFFFF);
    repeat (400) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check_val("async reset leds", leds, 0);
    check_val("async reset pat_ready", pat_ready, 1);
    check_val("async reset busy", busy, 0);
    repeat (3) @(negedge clk);
    check_val("reset held pat_ready", pat_ready, 1);
    resetn = 1'b1;
    check_dark("leds dark after mid-fade reset", 300);
    send(16'h0001);
    wait_ready(n, nb);
    check_val("post-reset fade-in cycles", n, FadeLen);
    check_duty("post-reset 0001", 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
